// File: rtl/e203_icb_sram_resp_if.sv
// ICB command/response bundle between the LSU data path and the SRAM responder.
// master drives commands and rsp_ready; slave drives cmd_ready and the response.
interface e203_icb_sram_resp_if #(
  parameter int AW = 32
);
  logic          icb_cmd_valid;
  logic          icb_cmd_ready;
  logic [AW-1:0] icb_cmd_addr;
  logic          icb_cmd_read;
  logic [31:0]   icb_cmd_wdata;
  logic [3:0]    icb_cmd_wmask;
  logic [1:0]    icb_cmd_size;
  logic          icb_cmd_excl;
  logic          icb_rsp_valid;
  logic          icb_rsp_ready;
  logic          icb_rsp_err;
  logic          icb_rsp_excl_ok;
  logic [31:0]   icb_rsp_rdata;

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata,
           icb_cmd_wmask, icb_cmd_size, icb_cmd_excl, icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_excl_ok,
           icb_rsp_rdata
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata,
           icb_cmd_wmask, icb_cmd_size, icb_cmd_excl, icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_excl_ok,
           icb_rsp_rdata
  );
endinterface

// File: rtl/e203_icb_sram_resp.sv
// ICB responder for a 1-cycle-latency word SRAM: decode/align checks, 1-deep access stage, 3-entry in-order response queue.
// Latency: handshake in N -> response valid in N+2. Backpressure: cmd_ready drops once queue + in-flight reach 3. Optional E203_ICB_SRAM_EXCL_EN adds an exclusive monitor.
module e203_icb_sram_resp #(
  parameter int            AW     = 32,
  parameter int            RAM_AW = 12,
  parameter logic [AW-1:0] BASE   = 32'h9000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  e203_icb_sram_resp_if.slave   icb,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic [3:0]            ram_wem,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout
);

  typedef struct packed {
    logic        err;
    logic        xok;
    logic [31:0] rdata;
  } rsp_ent_t;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  logic [1:0] cnt;
  logic [1:0] wptr;
  logic [1:0] rptr;
  rsp_ent_t   q [3];
  rsp_ent_t   push_ent;

  logic p_vld, p_rd, p_err, p_xok;
  logic hsk, hit, mis, err, sup, xok, push, pop;

  // Space is reserved for the in-flight access, so a push never finds the queue full.
  assign icb.icb_cmd_ready = ~rst & (({1'b0, cnt} + {2'b00, p_vld}) < 3'd3);
  assign hsk = icb.icb_cmd_valid & icb.icb_cmd_ready;

  assign hit = (icb.icb_cmd_addr[AW-1:RAM_AW+2] == BASE[AW-1:RAM_AW+2]);
  assign mis = ((icb.icb_cmd_size == 2'b01) & icb.icb_cmd_addr[0])
             | ((icb.icb_cmd_size == 2'b10) & (|icb.icb_cmd_addr[1:0]))
             |  (icb.icb_cmd_size == 2'b11);
  assign err = ~hit | mis;

`ifdef E203_ICB_SRAM_EXCL_EN
  logic          resv_vld;
  logic [AW-3:0] resv_addr;
  logic          resv_hit;

  assign resv_hit = resv_vld & (resv_addr == icb.icb_cmd_addr[AW-1:2]);
  assign sup = icb.icb_cmd_excl & ~icb.icb_cmd_read & ~err & ~resv_hit;
  assign xok = icb.icb_cmd_excl & ~err & (icb.icb_cmd_read | resv_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      resv_vld  <= 1'b0;
      resv_addr <= '0;
    end else if (hsk & ~err) begin
      if (icb.icb_cmd_excl & icb.icb_cmd_read) begin
        resv_vld  <= 1'b1;
        resv_addr <= icb.icb_cmd_addr[AW-1:2];
      end else if (~icb.icb_cmd_read & (icb.icb_cmd_excl | resv_hit)) begin
        resv_vld  <= 1'b0;
      end
    end
  end
`else
  logic unused_excl;
  assign unused_excl = icb.icb_cmd_excl;
  assign sup = 1'b0;
  assign xok = 1'b0;
`endif

  assign ram_cs   = hsk & ~err & ~sup;
  assign ram_we   = ram_cs & ~icb.icb_cmd_read;
  assign ram_addr = icb.icb_cmd_addr[RAM_AW+1:2];
  assign ram_wem  = icb.icb_cmd_wmask;
  assign ram_din  = icb.icb_cmd_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_vld <= 1'b0;
      p_rd  <= 1'b0;
      p_err <= 1'b0;
      p_xok <= 1'b0;
    end else begin
      p_vld <= hsk;
      if (hsk) begin
        p_rd  <= icb.icb_cmd_read;
        p_err <= err;
        p_xok <= xok;
      end
    end
  end

  always_comb begin
    push_ent       = '0;
    push_ent.err   = p_err;
    push_ent.xok   = p_xok;
    push_ent.rdata = (p_rd & ~p_err) ? ram_dout : 32'h0;
  end

  assign push = p_vld;
  assign pop  = icb.icb_rsp_valid & icb.icb_rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 2'd0;
      wptr <= 2'd0;
      rptr <= 2'd0;
    end else begin
      if (push) begin
        q[wptr] <= push_ent;
        wptr    <= ptr_inc(wptr);
      end
      if (pop) rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Head fields are masked so stale entries never show on an idle bus.
  assign icb.icb_rsp_valid   = (cnt != 2'd0);
  assign icb.icb_rsp_err     = icb.icb_rsp_valid & q[rptr].err;
  assign icb.icb_rsp_excl_ok = icb.icb_rsp_valid & q[rptr].xok;
  assign icb.icb_rsp_rdata   = icb.icb_rsp_valid ? q[rptr].rdata : 32'h0;

endmodule

// File: tb/tb_e203_icb_sram_resp.sv
// Bench for e203_icb_sram_resp: SRAM model, reference memory/reservation model, response scoreboard.
module tb_e203_icb_sram_resp;
  localparam logic [31:0] BASE = 32'h9000_0000;

  typedef struct packed {
    logic        err;
    logic        xok;
    logic [31:0] rdata;
  } rsp_t;

`ifdef E203_ICB_SRAM_EXCL_EN
  localparam logic [6:0]  XOK_EXP = 7'b0110001;
  localparam logic [31:0] MID_EXP = 32'hAAAA_0001;
`else
  localparam logic [6:0]  XOK_EXP = 7'b0000000;
  localparam logic [31:0] MID_EXP = 32'hBBBB_0002;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_cs, ram_we;
  logic [11:0] ram_addr;
  logic [3:0]  ram_wem;
  logic [31:0] ram_din;
  logic [31:0] ram_dout = 32'h0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cs_cnt = 0;
  int outst  = 0;

  rsp_t exp_q[$];
  rsp_t act_q[$];
  int   act_cyc[$];
  int   hs_cyc[$];

  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic        ref_resv_vld = 1'b0;
  logic [29:0] ref_resv_addr = '0;

  e203_icb_sram_resp_if #(.AW(32)) icb ();

  e203_icb_sram_resp #(.AW(32), .RAM_AW(12), .BASE(BASE)) dut (
    .clk      (clk),
    .rst      (rst),
    .icb      (icb),
    .ram_cs   (ram_cs),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wem  (ram_wem),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_wem[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  always @(negedge clk) begin
    if (ram_cs) cs_cnt++;
    if (rst) begin
      outst = 0;
    end else begin
      if (icb.icb_cmd_valid && icb.icb_cmd_ready) begin
        hs_cyc.push_back(cyc);
        outst++;
      end
      if (icb.icb_rsp_valid && icb.icb_rsp_ready) begin
        act_q.push_back('{icb.icb_rsp_err, icb.icb_rsp_excl_ok, icb.icb_rsp_rdata});
        act_cyc.push_back(cyc);
        outst--;
      end
      total++;
      if (outst > 3) begin
        bad++;
        $display("FAIL outstanding: got %0d, limit 3", outst);
      end
    end
  end

  function automatic rsp_t model_cmd(input logic [31:0] addr, input logic rd,
                                     input logic [31:0] wd, input logic [3:0] wm,
                                     input logic [1:0] sz, input logic ex);
    rsp_t r;
    logic hit, mis, wr_ok;
    logic [11:0] idx;
    r   = '0;
    hit = (addr[31:14] == BASE[31:14]);
    mis = (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0) || (sz == 2'd3);
    if (!hit || mis) begin
      r.err = 1'b1;
      return r;
    end
    idx   = addr[13:2];
    wr_ok = 1'b1;
    if (rd) begin
      r.rdata = ref_mem[idx];
`ifdef E203_ICB_SRAM_EXCL_EN
      if (ex) begin
        ref_resv_vld  = 1'b1;
        ref_resv_addr = addr[31:2];
        r.xok         = 1'b1;
      end
`endif
    end else begin
`ifdef E203_ICB_SRAM_EXCL_EN
      if (ex) begin
        wr_ok        = ref_resv_vld && (ref_resv_addr == addr[31:2]);
        r.xok        = wr_ok;
        ref_resv_vld = 1'b0;
      end else if (ref_resv_vld && ref_resv_addr == addr[31:2]) begin
        ref_resv_vld = 1'b0;
      end
`endif
      if (wr_ok)
        for (int b = 0; b < 4; b++)
          if (wm[b]) ref_mem[idx][b*8 +: 8] = wd[b*8 +: 8];
    end
    return r;
  endfunction

  task automatic send(input logic [31:0] addr, input logic rd, input logic [31:0] wd,
                      input logic [3:0] wm, input logic [1:0] sz, input logic ex);
    logic hs;
    exp_q.push_back(model_cmd(addr, rd, wd, wm, sz, ex));
    icb.icb_cmd_valid = 1'b1;
    icb.icb_cmd_addr  = addr;
    icb.icb_cmd_read  = rd;
    icb.icb_cmd_wdata = wd;
    icb.icb_cmd_wmask = wm;
    icb.icb_cmd_size  = sz;
    icb.icb_cmd_excl  = ex;
    hs = 1'b0;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk);
      hs = icb.icb_cmd_ready;
      @(posedge clk);
      #1;
    end
    icb.icb_cmd_valid = 1'b0;
    total++;
    if (!hs) begin
      bad++;
      $display("FAIL cmd_accept addr=%h: got no handshake, required handshake within 100 cycles", addr);
    end
  endtask

  task automatic wait_rsps(input int n);
    for (int i = 0; i < 400 && act_q.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_stamps();
    hs_cyc.delete();
    act_cyc.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (icb.icb_cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_cmd_ready: got %b, required 0", icb.icb_cmd_ready);
    end
    total++;
    if ({icb.icb_rsp_valid, ram_cs, ram_we, icb.icb_rsp_err, icb.icb_rsp_excl_ok, icb.icb_rsp_rdata} !== 37'h0) begin
      bad++;
      $display("FAIL reset_outputs: got vld=%b cs=%b we=%b err=%b xok=%b rdata=%h, required all 0",
               icb.icb_rsp_valid, ram_cs, ram_we, icb.icb_rsp_err, icb.icb_rsp_excl_ok, icb.icb_rsp_rdata);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (icb.icb_cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_ready: got %b, required 1", icb.icb_cmd_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    rsp_t a, e;
    clear_stamps();
    send(BASE + 32'h10, 1'b0, 32'hDEAD_BEEF, 4'hF, 2'd2, 1'b0);
    send(BASE + 32'h10, 1'b1, 32'h0, 4'h0, 2'd2, 1'b0);
    wait_rsps(2);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (act_q.size() == 0 || exp_q.size() == 0) begin
        bad++;
        $display("FAIL wr_rd_rsp%0d: got no response, required one", i);
      end else begin
        a = act_q.pop_front();
        e = exp_q.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL wr_rd_rsp%0d: got %h, required %h", i, a, e);
        end
        if (i == 1) begin
          total++;
          if (a.rdata !== 32'hDEAD_BEEF || a.err !== 1'b0) begin
            bad++;
            $display("FAIL wr_rd_data: got %h err=%b, required deadbeef err=0", a.rdata, a.err);
          end
        end
      end
    end
    total++;
    if (hs_cyc.size() < 2 || act_cyc.size() < 2 || act_cyc[1] - hs_cyc[1] != 2) begin
      bad++;
      $display("FAIL read_latency: got %0d, required 2",
               (hs_cyc.size() < 2 || act_cyc.size() < 2) ? -1 : act_cyc[1] - hs_cyc[1]);
    end
  endtask

  task automatic test_byte_write();
    rsp_t a, e;
    send(BASE + 32'h10, 1'b0, 32'h1122_3344, 4'hF, 2'd2, 1'b0);
    send(BASE + 32'h13, 1'b0, 32'h5A5A_5A5A, 4'h8, 2'd0, 1'b0);
    send(BASE + 32'h10, 1'b1, 32'h0, 4'h0, 2'd2, 1'b0);
    wait_rsps(3);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (act_q.size() == 0 || exp_q.size() == 0) begin
        bad++;
        $display("FAIL byte_rsp%0d: got no response, required one", i);
      end else begin
        a = act_q.pop_front();
        e = exp_q.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL byte_rsp%0d: got %h, required %h", i, a, e);
        end
        if (i == 2) begin
          total++;
          if (a.rdata !== 32'h5A22_3344) begin
            bad++;
            $display("FAIL byte_merge: got %h, required 5a223344", a.rdata);
          end
        end
      end
    end
  endtask

  task automatic test_errors();
    rsp_t a, e;
    int cs0;
    cs0 = cs_cnt;
    send(BASE + 32'h2, 1'b1, 32'h0, 4'h0, 2'd2, 1'b0);
    send(BASE + 32'h4000, 1'b1, 32'h0, 4'h0, 2'd2, 1'b0);
    send(BASE, 1'b1, 32'h0, 4'h0, 2'd3, 1'b0);
    wait_rsps(3);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (act_q.size() == 0 || exp_q.size() == 0) begin
        bad++;
        $display("FAIL err_rsp%0d: got no response, required one", i);
      end else begin
        a = act_q.pop_front();
        e = exp_q.pop_front();
        if (a !== e || a !== 34'h2_0000_0000) begin
          bad++;
          $display("FAIL err_rsp%0d: got %h, required %h (err=1 rdata=0)", i, a, e);
        end
      end
    end
    total++;
    if (cs_cnt != cs0) begin
      bad++;
      $display("FAIL err_ram_cs: got %0d selects, required 0", cs_cnt - cs0);
    end
  endtask

  task automatic test_backpressure();
    rsp_t a, e;
    for (int i = 0; i < 5; i++)
      send(BASE + 32'h100 + 32'(4 * i), 1'b0, 32'hA500_0000 + 32'(i), 4'hF, 2'd2, 1'b0);
    wait_rsps(5);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (act_q.size() == 0 || exp_q.size() == 0) begin
        bad++;
        $display("FAIL bp_wr%0d: got no response, required one", i);
      end else begin
        a = act_q.pop_front();
        e = exp_q.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL bp_wr%0d: got %h, required %h", i, a, e);
        end
      end
    end
    clear_stamps();
    icb.icb_rsp_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(BASE + 32'h100 + 32'(4 * i), 1'b1, 32'h0, 4'h0, 2'd2, 1'b0);
      end
    join_none
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    total++;
    if (hs_cyc.size() != 3 || icb.icb_cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_accept: got %0d accepted ready=%b, required 3 ready=0", hs_cyc.size(), icb.icb_cmd_ready);
    end
    @(posedge clk);
    #1;
    icb.icb_rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (icb.icb_cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_ready_pop: got %b, required 0", icb.icb_cmd_ready);
    end
    @(negedge clk);
    total++;
    if (icb.icb_cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_ready_after_pop: got %b, required 1", icb.icb_cmd_ready);
    end
    @(posedge clk);
    #1;
    wait_rsps(5);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (act_q.size() == 0 || exp_q.size() == 0) begin
        bad++;
        $display("FAIL bp_rd%0d: got no response, required one", i);
      end else begin
        a = act_q.pop_front();
        e = exp_q.pop_front();
        if (a !== e || a.rdata !== 32'hA500_0000 + 32'(i)) begin
          bad++;
          $display("FAIL bp_rd%0d: got %h, required %h", i, a, e);
        end
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_streaming();
    rsp_t a, e;
    clear_stamps();
    for (int i = 0; i < 16; i++)
      send(BASE + 32'(4 * i), 1'b1, 32'h0, 4'h0, 2'd2, 1'b0);
    wait_rsps(16);
    total++;
    if (hs_cyc.size() != 16 || hs_cyc[15] - hs_cyc[0] != 15) begin
      bad++;
      $display("FAIL stream_cmd: got %0d handshakes not back-to-back, required 16 in 16 cycles", hs_cyc.size());
    end
    total++;
    if (act_cyc.size() != 16 || act_cyc[15] - act_cyc[0] != 15 || act_cyc[0] - hs_cyc[0] != 2) begin
      bad++;
      $display("FAIL stream_rsp: got %0d responses not consecutive, required 16 consecutive", act_cyc.size());
    end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (act_q.size() == 0 || exp_q.size() == 0) begin
        bad++;
        $display("FAIL stream_rsp%0d: got no response, required one", i);
      end else begin
        a = act_q.pop_front();
        e = exp_q.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL stream_rsp%0d: got %h, required %h", i, a, e);
        end
      end
    end
  endtask

  task automatic test_excl();
    rsp_t a, e;
    rsp_t got [7];
    logic [6:0] xok_v;
    logic [31:0] A;
    A = BASE + 32'h80;
    send(A, 1'b1, 32'h0,         4'h0, 2'd2, 1'b1);
    send(A, 1'b0, 32'hAAAA_0001, 4'hF, 2'd2, 1'b0);
    send(A, 1'b0, 32'hBBBB_0002, 4'hF, 2'd2, 1'b1);
    send(A, 1'b1, 32'h0,         4'h0, 2'd2, 1'b0);
    send(A, 1'b1, 32'h0,         4'h0, 2'd2, 1'b1);
    send(A, 1'b0, 32'hCCCC_0003, 4'hF, 2'd2, 1'b1);
    send(A, 1'b1, 32'h0,         4'h0, 2'd2, 1'b0);
    wait_rsps(7);
    xok_v = '0;
    for (int i = 0; i < 7; i++) begin
      got[i] = '0;
      total++;
      if (act_q.size() == 0 || exp_q.size() == 0) begin
        bad++;
        $display("FAIL excl_rsp%0d: got no response, required one", i);
      end else begin
        a = act_q.pop_front();
        e = exp_q.pop_front();
        got[i]   = a;
        xok_v[i] = a.xok;
        if (a !== e) begin
          bad++;
          $display("FAIL excl_rsp%0d: got %h, required %h", i, a, e);
        end
      end
    end
    total++;
    if (xok_v !== XOK_EXP) begin
      bad++;
      $display("FAIL excl_ok_seq: got %b, required %b", xok_v, XOK_EXP);
    end
    total++;
    if (got[3].rdata !== MID_EXP || got[6].rdata !== 32'hCCCC_0003) begin
      bad++;
      $display("FAIL excl_mem: got %h/%h, required %h/cccc0003", got[3].rdata, got[6].rdata, MID_EXP);
    end
  endtask

  task automatic test_reset_mid();
    rsp_t a, e;
    int cs0;
    icb.icb_rsp_ready = 1'b0;
    send(BASE + 32'h10, 1'b1, 32'h0, 4'h0, 2'd2, 1'b0);
    send(BASE + 32'h14, 1'b1, 32'h0, 4'h0, 2'd2, 1'b0);
    rst = 1'b1;
    icb.icb_cmd_valid = 1'b1;
    icb.icb_cmd_addr  = BASE + 32'h10;
    icb.icb_cmd_read  = 1'b0;
    icb.icb_cmd_wdata = 32'hFFFF_FFFF;
    icb.icb_cmd_wmask = 4'hF;
    icb.icb_cmd_size  = 2'd2;
    icb.icb_cmd_excl  = 1'b0;
    cs0 = cs_cnt;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (icb.icb_rsp_valid !== 1'b0 || icb.icb_cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_out: got vld=%b rdy=%b, required 0/0", icb.icb_rsp_valid, icb.icb_cmd_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    icb.icb_cmd_valid = 1'b0;
    icb.icb_rsp_ready = 1'b1;
    total++;
    if (cs_cnt != cs0) begin
      bad++;
      $display("FAIL mid_reset_ram: got %0d selects, required 0", cs_cnt - cs0);
    end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (act_q.size() != 0) begin
      bad++;
      $display("FAIL mid_reset_drop: got %0d responses, required 0", act_q.size());
    end
    exp_q.delete();
    act_q.delete();
    ref_resv_vld = 1'b0;
    send(BASE + 32'h10, 1'b1, 32'h0, 4'h0, 2'd2, 1'b0);
    wait_rsps(1);
    total++;
    if (act_q.size() == 0 || exp_q.size() == 0) begin
      bad++;
      $display("FAIL mid_reset_read: got no response, required one");
    end else begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      if (a !== e) begin
        bad++;
        $display("FAIL mid_reset_read: got %h, required %h", a, e);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    icb.icb_cmd_valid = 1'b0;
    icb.icb_cmd_addr  = '0;
    icb.icb_cmd_read  = 1'b0;
    icb.icb_cmd_wdata = '0;
    icb.icb_cmd_wmask = '0;
    icb.icb_cmd_size  = '0;
    icb.icb_cmd_excl  = 1'b0;
    icb.icb_rsp_ready = 1'b1;
    test_reset();
    test_write_read();
    test_byte_write();
    test_errors();
    test_backpressure();
    test_streaming();
    test_excl();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
